decode_execute_reg: RTL
=======================

Name: decode_execute_reg

Overview:
Pipeline register between the decode stage and the combined execute/memory stage, in a 4-stage pipeline: F, D, EX/MEM, WB.
- Captures decoded operands and control fields each cycle.
- Supports stall (hold) and flush (bubble).
- Forwards writeback results at two points: capture-time (regfile write/read in the same cycle) and output-time (producer one instruction ahead, now in WB).
- Its outputs drive the execute/memory stage's SrcA, WriteData, ImmExt, ALUControl, ALUSrc and MemWrite directly.

Parameters:
XLEN, 32, datapath width
RADDR_W, 5, register index width
ALUCTL_W, 3, ALU control width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  hold current contents
flush  in  1  replace contents with bubble next edge (taken branch)
d_valid  in  1  decode slot holds a real instruction
d_pc  in  XLEN  decode PC
d_rd1  in  XLEN  regfile read data rs1
d_rd2  in  XLEN  regfile read data rs2
d_imm_ext  in  XLEN  extended immediate
d_rs1  in  RADDR_W  source index 1
d_rs2  in  RADDR_W  source index 2
d_rd  in  RADDR_W  destination index
d_alu_control  in  ALUCTL_W  ALU operation
d_alu_src, d_mem_write, d_reg_write, d_result_src, d_branch  in  1 each  decoded controls
w_reg_write  in  1  WB stage writes regfile
w_rd  in  RADDR_W  WB destination index
w_result  in  XLEN  WB result value
e_valid  out  1  EX slot holds a real instruction
e_pc, e_src_a, e_write_data, e_imm_ext  out  XLEN each  forwarded operands and immediate to EX/MEM
e_rs1, e_rs2, e_rd  out  RADDR_W each  registered indices
e_alu_control  out  ALUCTL_W
e_alu_src, e_mem_write, e_reg_write, e_result_src, e_branch  out  1 each

Behaviour:
- Reset (rst_n low, async): all registered fields 0, so e_valid=0 and all controls 0. e_src_a and e_write_data then show 0 unless the output-time forward fires.
- wb_hit(idx) = w_reg_write && w_rd!=0 && w_rd==idx.

Per rising edge, priority flush > stall > load:
- flush=1:
  - Bubble: valid, reg_write, mem_write, branch cleared.
  - All other fields zeroed.
  - Applies regardless of stall.
- stall=1, flush=0:
  - All fields hold.
  - Refresh: if wb_hit(e_rs1), the stored rs1 operand becomes w_result; same for rs2.
  - The refresh keeps a producer leaving WB during the stall from being lost.
- Otherwise, load:
  - All fields take the d_* values.
  - Stored rs1 operand = wb_hit(d_rs1) ? w_result : d_rd1 (capture bypass); same for rs2.
  - If d_valid=0, a bubble is loaded exactly as for flush.

Outputs:
- e_src_a = wb_hit(e_rs1) && e_valid ? w_result : stored rs1 operand.
- e_write_data follows the same rule with rs2.
- All other outputs are the registered values directly.
- Latency: d_* to e_* is one cycle.
- Index 0 is never forwarded; the register-0 read value passes through unchanged.
- Bubbles never assert e_mem_write, e_reg_write or e_branch.
- Reset mid-stall: immediate bubble; the held instruction is discarded.

Decomposition:
- Shared package: XLEN, RADDR_W, ALUCTL_W, ALUControl encodings, result_src encodings (0=ALU, 1=memory), bubble constant for the control bundle.
- Sub-module wb_bypass: combinational 2:1 select on wb_hit. Instantiated four times: capture rs1, capture rs2, output rs1, output rs2.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then d_valid=0 -> all e_* 0, e_valid=0, e_mem_write=0.
- Plain load: d_rd1=5, d_rd2=7, d_imm_ext=0xFFFFFFFC, d_alu_control=3'b010, d_reg_write=1, no WB hit -> next cycle e_src_a=5, e_write_data=7, e_imm_ext=0xFFFFFFFC, e_alu_control=3'b010, e_valid=1.
- Output forward: e_rs1=3 stored 0x10; drive w_reg_write=1, w_rd=3, w_result=0x99 -> e_src_a=0x99 the same cycle. With w_rd=0 instead -> e_src_a stays 0x10.
- Capture bypass: d_rs2=4, d_rd2=1, w_rd=4, w_result=0x55, w_reg_write=1 at the edge -> e_write_data=0x55 after the edge, with no WB hit that cycle.
- Stall refresh: stall=1 for 3 cycles with e_rs1=6; in cycle 2 w_rd=6, w_result=0xAB -> stored operand 0xAB. After WB changes, e_src_a remains 0xAB; other fields unchanged.
- Flush vs stall, then async reset: stall=1 and flush=1 on the same edge -> bubble (e_valid=0, e_mem_write=0). Then drop rst_n mid-cycle during a valid load -> outputs clear immediately, without waiting for clk.

Source files
------------

// File: rtl/decode_execute_reg_pkg.sv
// decode_execute_reg_pkg: shared widths, encodings and control bundle for the D->EX register
package decode_execute_reg_pkg;
  localparam int XLEN     = 32;
  localparam int RADDR_W  = 5;
  localparam int ALUCTL_W = 3;
  typedef enum logic [ALUCTL_W-1:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_op_e;
  typedef enum logic {
    RES_ALU = 1'b0,
    RES_MEM = 1'b1
  } result_src_e;
  typedef struct packed {
    logic                valid;
    logic [ALUCTL_W-1:0] alu_control;
    logic                alu_src;
    logic                mem_write;
    logic                reg_write;
    logic                result_src;
    logic                branch;
  } ctrl_t;
  localparam ctrl_t CTRL_BUBBLE = '0;
  function automatic logic wb_hit(input logic w_reg_write, input logic [RADDR_W-1:0] w_rd,
                                  input logic [RADDR_W-1:0] idx);
    return w_reg_write && (w_rd != '0) && (w_rd == idx);
  endfunction
endpackage

// File: rtl/decode_execute_reg_wb_bypass.sv
// wb_bypass: picks the writeback result over a register value when WB writes that register
module wb_bypass
  import decode_execute_reg_pkg::*;
(
  input  logic               en,
  input  logic               w_reg_write,
  input  logic [RADDR_W-1:0] w_rd,
  input  logic [XLEN-1:0]    w_result,
  input  logic [RADDR_W-1:0] idx,
  input  logic [XLEN-1:0]    val,
  output logic [XLEN-1:0]    y
);
  assign y = (en && wb_hit(w_reg_write, w_rd, idx)) ? w_result : val;
endmodule

// File: rtl/decode_execute_reg.sv
// decode_execute_reg: D->EX/MEM pipeline register with stall, flush and WB forwarding
module decode_execute_reg
  import decode_execute_reg_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                flush,
  input  logic                d_valid,
  input  logic [XLEN-1:0]     d_pc,
  input  logic [XLEN-1:0]     d_rd1,
  input  logic [XLEN-1:0]     d_rd2,
  input  logic [XLEN-1:0]     d_imm_ext,
  input  logic [RADDR_W-1:0]  d_rs1,
  input  logic [RADDR_W-1:0]  d_rs2,
  input  logic [RADDR_W-1:0]  d_rd,
  input  logic [ALUCTL_W-1:0] d_alu_control,
  input  logic                d_alu_src,
  input  logic                d_mem_write,
  input  logic                d_reg_write,
  input  logic                d_result_src,
  input  logic                d_branch,
  input  logic                w_reg_write,
  input  logic [RADDR_W-1:0]  w_rd,
  input  logic [XLEN-1:0]     w_result,
  output logic                e_valid,
  output logic [XLEN-1:0]     e_pc,
  output logic [XLEN-1:0]     e_src_a,
  output logic [XLEN-1:0]     e_write_data,
  output logic [XLEN-1:0]     e_imm_ext,
  output logic [RADDR_W-1:0]  e_rs1,
  output logic [RADDR_W-1:0]  e_rs2,
  output logic [RADDR_W-1:0]  e_rd,
  output logic [ALUCTL_W-1:0] e_alu_control,
  output logic                e_alu_src,
  output logic                e_mem_write,
  output logic                e_reg_write,
  output logic                e_result_src,
  output logic                e_branch
);
  ctrl_t ctrl_q, ctrl_d, d_ctrl;
  logic [XLEN-1:0] pc_q, pc_d, op_a_q, op_a_d, op_b_q, op_b_d, imm_q, imm_d;
  logic [RADDR_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [XLEN-1:0] cap_a, cap_b;
  assign d_ctrl = '{valid: d_valid, alu_control: d_alu_control, alu_src: d_alu_src,
                    mem_write: d_mem_write, reg_write: d_reg_write,
                    result_src: d_result_src, branch: d_branch};
  wb_bypass u_cap_a (.en(1'b1), .w_reg_write(w_reg_write), .w_rd(w_rd), .w_result(w_result),
                     .idx(d_rs1), .val(d_rd1), .y(cap_a));
  wb_bypass u_cap_b (.en(1'b1), .w_reg_write(w_reg_write), .w_rd(w_rd), .w_result(w_result),
                     .idx(d_rs2), .val(d_rd2), .y(cap_b));
  wb_bypass u_out_a (.en(ctrl_q.valid), .w_reg_write(w_reg_write), .w_rd(w_rd), .w_result(w_result),
                     .idx(rs1_q), .val(op_a_q), .y(e_src_a));
  wb_bypass u_out_b (.en(ctrl_q.valid), .w_reg_write(w_reg_write), .w_rd(w_rd), .w_result(w_result),
                     .idx(rs2_q), .val(op_b_q), .y(e_write_data));
  // next state: bubble on flush or invalid load, hold with operand refresh on stall, else load
  always_comb begin
    ctrl_d = ctrl_q;
    pc_d   = pc_q;
    imm_d  = imm_q;
    rs1_d  = rs1_q;
    rs2_d  = rs2_q;
    rd_d   = rd_q;
    op_a_d = wb_hit(w_reg_write, w_rd, rs1_q) ? w_result : op_a_q;
    op_b_d = wb_hit(w_reg_write, w_rd, rs2_q) ? w_result : op_b_q;
    if (flush || (!stall && !d_valid)) begin
      ctrl_d = CTRL_BUBBLE;
      pc_d   = '0;
      imm_d  = '0;
      rs1_d  = '0;
      rs2_d  = '0;
      rd_d   = '0;
      op_a_d = '0;
      op_b_d = '0;
    end else if (!stall) begin
      ctrl_d = d_ctrl;
      pc_d   = d_pc;
      imm_d  = d_imm_ext;
      rs1_d  = d_rs1;
      rs2_d  = d_rs2;
      rd_d   = d_rd;
      op_a_d = cap_a;
      op_b_d = cap_b;
    end
  end
  // state registers, cleared asynchronously so reset drops any held instruction at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= CTRL_BUBBLE;
      pc_q   <= '0;
      imm_q  <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      rd_q   <= '0;
      op_a_q <= '0;
      op_b_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      pc_q   <= pc_d;
      imm_q  <= imm_d;
      rs1_q  <= rs1_d;
      rs2_q  <= rs2_d;
      rd_q   <= rd_d;
      op_a_q <= op_a_d;
      op_b_q <= op_b_d;
    end
  end
  assign e_valid       = ctrl_q.valid;
  assign e_alu_control = ctrl_q.alu_control;
  assign e_alu_src     = ctrl_q.alu_src;
  assign e_mem_write   = ctrl_q.mem_write;
  assign e_reg_write   = ctrl_q.reg_write;
  assign e_result_src  = ctrl_q.result_src;
  assign e_branch      = ctrl_q.branch;
  assign e_pc          = pc_q;
  assign e_imm_ext     = imm_q;
  assign e_rs1         = rs1_q;
  assign e_rs2         = rs2_q;
  assign e_rd          = rd_q;
endmodule
